// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-back data cache.
package dcache_pkg;

   localparam int WORD_W        = 32;
   localparam int DEF_LINE_BITS = 256;
   localparam int DEF_IDX_W     = 4;
   localparam int DEF_OFF_W     = 3;
   localparam int DEF_TAG_W     = 32 - DEF_IDX_W - DEF_OFF_W - 2;

   typedef logic [DEF_LINE_BITS-1:0] line_t;

   typedef enum logic [1:0] {
      IDLE,
      WB,
      FILL,
      REFILL
   } state_t;

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: asynchronous read, synchronous line or word write,
// asynchronous clear of the valid and dirty bits.
module dcache_sram
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int LINE_BITS = DEF_LINE_BITS,
   parameter int TAG_W     = DEF_TAG_W,
   parameter int IDX_W     = $clog2(NUM_LINES),
   parameter int OFF_W     = $clog2(LINE_BITS / WORD_W)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [IDX_W-1:0]     idx,
   output logic                 rd_valid,
   output logic                 rd_dirty,
   output logic [TAG_W-1:0]     rd_tag,
   output logic [LINE_BITS-1:0] rd_line,
   input  logic                 line_we,
   input  logic [TAG_W-1:0]     wr_tag,
   input  logic [LINE_BITS-1:0] wr_line,
   input  logic                 word_we,
   input  logic [OFF_W-1:0]     wr_off,
   input  logic [WORD_W-1:0]    wr_word
);

   logic [NUM_LINES-1:0] valid_q;
   logic [NUM_LINES-1:0] dirty_q;
   logic [TAG_W-1:0]     tag_q  [NUM_LINES];
   logic [LINE_BITS-1:0] data_q [NUM_LINES];

   assign rd_valid = valid_q[idx];
   assign rd_dirty = dirty_q[idx];
   assign rd_tag   = tag_q[idx];
   assign rd_line  = data_q[idx];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= '0;
         dirty_q <= '0;
      end else if (line_we) begin
         valid_q[idx] <= 1'b1;
         dirty_q[idx] <= 1'b0;
      end else if (word_we) begin
         dirty_q[idx] <= 1'b1;
      end
   end

   // Payload arrays need no reset; a line is only trusted once its valid bit is set.
   always_ff @(posedge clk_i) begin
      if (line_we) begin
         tag_q[idx]  <= wr_tag;
         data_q[idx] <= wr_line;
      end else if (word_we) begin
         data_q[idx][wr_off*WORD_W +: WORD_W] <= wr_word;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache controller with miss FSM.
// Define DCACHE_STATS_EN to add saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16,
   parameter int LINE_BITS = DEF_LINE_BITS
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cpu_req_i,
   input  logic                 cpu_we_i,
   input  logic [31:0]          cpu_addr_i,
   input  logic [31:0]          cpu_data_i,
   output logic [31:0]          cpu_data_o,
   output logic                 mem_stall_o,
   output logic                 mem_enable_o,
   output logic                 mem_write_o,
   output logic [31:0]          mem_addr_o,
   output logic [LINE_BITS-1:0] mem_data_o,
   input  logic [LINE_BITS-1:0] mem_data_i,
   input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]          hit_cnt_o,
   output logic [31:0]          miss_cnt_o
`endif
);

   localparam int IDX_W    = $clog2(NUM_LINES);
   localparam int OFF_W    = $clog2(LINE_BITS / WORD_W);
   localparam int LINE_OFF = OFF_W + 2;
   localparam int TAG_W    = 32 - IDX_W - LINE_OFF;

   state_t               state_q, state_d;
   logic [TAG_W-1:0]     req_tag;
   logic [IDX_W-1:0]     req_idx;
   logic [OFF_W-1:0]     req_off;
   logic                 rd_valid, rd_dirty, hit;
   logic [TAG_W-1:0]     rd_tag;
   logic [LINE_BITS-1:0] rd_line, fill_q;
   logic                 line_we, word_we;
   logic                 unused_addr_bits;

   assign req_tag          = cpu_addr_i[31 -: TAG_W];
   assign req_idx          = cpu_addr_i[LINE_OFF +: IDX_W];
   assign req_off          = cpu_addr_i[2 +: OFF_W];
   assign unused_addr_bits = ^cpu_addr_i[1:0];

   dcache_sram #(
      .NUM_LINES (NUM_LINES),
      .LINE_BITS (LINE_BITS),
      .TAG_W     (TAG_W)
   ) u_sram (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .idx      (req_idx),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .line_we  (line_we),
      .wr_tag   (req_tag),
      .wr_line  (fill_q),
      .word_we  (word_we),
      .wr_off   (req_off),
      .wr_word  (cpu_data_i)
   );

   assign hit        = cpu_req_i & rd_valid & (rd_tag == req_tag);
   assign cpu_data_o = (hit & ~cpu_we_i) ? rd_line[req_off*WORD_W +: WORD_W] : 32'd0;

   // Stall is forced low while reset is held so the pipeline is released immediately.
   assign mem_stall_o = ~rst_i & ((state_q != IDLE) | (cpu_req_i & ~hit));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_ff @(posedge clk_i) begin
      if (state_q == FILL && mem_ack_i) fill_q <= mem_data_i;
   end

   always_comb begin
      state_d      = state_q;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = 32'd0;
      mem_data_o   = '0;
      line_we      = 1'b0;
      word_we      = 1'b0;
      case (state_q)
         IDLE: begin
            word_we = hit & cpu_we_i;
            if (cpu_req_i && !hit) state_d = (rd_valid && rd_dirty) ? WB : FILL;
         end
         WB: begin
            mem_enable_o = 1'b1;
            mem_write_o  = 1'b1;
            mem_addr_o   = {rd_tag, req_idx, {LINE_OFF{1'b0}}};
            mem_data_o   = rd_line;
            if (mem_ack_i) state_d = FILL;
         end
         FILL: begin
            mem_enable_o = 1'b1;
            mem_addr_o   = {req_tag, req_idx, {LINE_OFF{1'b0}}};
            if (mem_ack_i) state_d = REFILL;
         end
         REFILL: begin
            line_we = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef DCACHE_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_cnt_o  <= 32'd0;
         miss_cnt_o <= 32'd0;
      end else begin
         if (state_q == IDLE && hit && hit_cnt_o != '1)
            hit_cnt_o <= hit_cnt_o + 32'd1;
         if (state_q == IDLE && state_d != IDLE && miss_cnt_o != '1)
            miss_cnt_o <= miss_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: cold/dirty/store misses, hits, reset abort.
module tb_dcache_controller;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cpuReq = 1'b0;
   logic         cpuWe = 1'b0;
   logic [31:0]  cpuAddr = 32'd0;
   logic [31:0]  cpuWdata = 32'd0;
   logic [31:0]  cpuRdata;
   logic         memStall, memEnable, memWrite, memAck = 1'b0;
   logic [31:0]  memAddr;
   logic [255:0] memWdata, memRdata = '0;

   int total = 0;
   int bad = 0;
   int stallCnt = 0;
   int stallStart = 0;

   logic [255:0] lineA, lineB, lineC, lineD, lineE, expLine;

   dcache_controller dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .cpu_req_i    (cpuReq),
      .cpu_we_i     (cpuWe),
      .cpu_addr_i   (cpuAddr),
      .cpu_data_i   (cpuWdata),
      .cpu_data_o   (cpuRdata),
      .mem_stall_o  (memStall),
      .mem_enable_o (memEnable),
      .mem_write_o  (memWrite),
      .mem_addr_o   (memAddr),
      .mem_data_o   (memWdata),
      .mem_data_i   (memRdata),
      .mem_ack_i    (memAck)
   );

   always #5 clk = ~clk;

   // Counts every cycle the pipeline is held, sampled mid-cycle after inputs settle.
   always @(negedge clk) begin
      #2;
      if (memStall === 1'b1) stallCnt++;
   end

   function automatic logic [255:0] makeLine(input logic [31:0] base);
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[32*i +: 32] = base + i;
      return l;
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [31:0] addr,
                                input logic [31:0] wdata);
      @(negedge clk);
      cpuReq = req; cpuWe = we; cpuAddr = addr; cpuWdata = wdata;
      #1;
   endtask

   task automatic hitAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] expData);
      applyStimulus(1'b1, we, addr, wdata);
      checkOutput("hit_stall", memStall, 1'b0);
      checkOutput("hit_enable", memEnable, 1'b0);
      checkOutput("hit_data", cpuRdata, expData);
   endtask

   task automatic detectMiss(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      applyStimulus(1'b1, we, addr, wdata);
      checkOutput("detect_stall", memStall, 1'b1);
      checkOutput("detect_enable", memEnable, 1'b0);
      stallStart = stallCnt;
   endtask

   // Serves one memory request: request must be held for lat cycles, ack on the last one.
   task automatic missPhase(input logic expWrite, input logic [31:0] expAddr, input int lat,
                            input logic [255:0] rdLine, input logic [255:0] expWb);
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         if (k == lat) begin
            memAck = 1'b1;
            memRdata = rdLine;
         end
         #1;
         checkOutput("req_enable", memEnable, 1'b1);
         checkOutput("req_write", memWrite, expWrite);
         checkOutput("req_addr", memAddr, expAddr);
         checkOutput("req_stall", memStall, 1'b1);
         if (expWrite) checkOutput("wb_data", memWdata, expWb);
      end
      @(posedge clk);
      #1 memAck = 1'b0;
   endtask

   task automatic finishMiss(input int expStall, input logic [31:0] expData);
      @(negedge clk); #1;
      checkOutput("refill_stall", memStall, 1'b1);
      checkOutput("refill_enable", memEnable, 1'b0);
      @(negedge clk); #1;
      checkOutput("after_stall", memStall, 1'b0);
      checkOutput("stall_len", stallCnt - stallStart, expStall);
      checkOutput("after_data", cpuRdata, expData);
   endtask

   initial begin
      lineA = makeLine(32'h1000_0000);
      lineA[32 +: 32] = 32'hDEAD_BEEF;
      lineB = makeLine(32'h2000_0000);
      lineC = makeLine(32'h3000_0000);
      lineD = makeLine(32'h4000_0000);
      lineE = makeLine(32'h5000_0000);

      // reset state
      applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
      checkOutput("rst_stall", memStall, 1'b0);
      checkOutput("rst_enable", memEnable, 1'b0);
      checkOutput("rst_write", memWrite, 1'b0);
      checkOutput("rst_addr", memAddr, 32'h0);
      checkOutput("rst_wdata", memWdata, 256'h0);
      checkOutput("rst_rdata", cpuRdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;

      // cold load miss, fill latency 10
      detectMiss(1'b0, 32'h0000_0104, 32'h0);
      missPhase(1'b0, 32'h0000_0100, 10, lineA, 256'h0);
      finishMiss(12, 32'hDEAD_BEEF);

      // hits: repeated load, store, load back, idle request
      hitAccess(1'b0, 32'h0000_0104, 32'h0, 32'hDEAD_BEEF);
      hitAccess(1'b1, 32'h0000_0108, 32'h1234_5678, 32'h0);
      hitAccess(1'b0, 32'h0000_0108, 32'h0, 32'h1234_5678);
      applyStimulus(1'b0, 1'b0, 32'h0000_0104, 32'h0);
      checkOutput("noreq_data", cpuRdata, 32'h0);
      checkOutput("noreq_stall", memStall, 1'b0);

      // dirty conflict miss: write-back of line 0x100 then fill from 0x300
      expLine = lineA;
      expLine[64 +: 32] = 32'h1234_5678;
      detectMiss(1'b0, 32'h0000_0308, 32'h0);
      missPhase(1'b1, 32'h0000_0100, 3, 256'h0, expLine);
      missPhase(1'b0, 32'h0000_0300, 4, lineB, 256'h0);
      finishMiss(9, 32'h2000_0002);

      // store miss allocates, then load hits
      detectMiss(1'b1, 32'h0000_0200, 32'hA5A5_A5A5);
      missPhase(1'b0, 32'h0000_0200, 2, lineC, 256'h0);
      finishMiss(4, 32'h0);
      hitAccess(1'b0, 32'h0000_0200, 32'h0, 32'hA5A5_A5A5);
      hitAccess(1'b0, 32'h0000_0204, 32'h0, 32'h3000_0001);

      // eviction of the stored line, both with single-cycle acks
      expLine = lineC;
      expLine[0 +: 32] = 32'hA5A5_A5A5;
      detectMiss(1'b0, 32'h0000_0000, 32'h0);
      missPhase(1'b1, 32'h0000_0200, 1, 256'h0, expLine);
      missPhase(1'b0, 32'h0000_0000, 1, lineD, 256'h0);
      finishMiss(4, 32'h4000_0000);

      // reset during FILL aborts the request
      detectMiss(1'b0, 32'h0000_0400, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0);
      checkOutput("fill_enable", memEnable, 1'b1);
      checkOutput("fill_addr", memAddr, 32'h0000_0400);
      @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("abort_enable", memEnable, 1'b0);
      checkOutput("abort_stall", memStall, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      cpuReq = 1'b0;
      #1;
      checkOutput("postrst_stall", memStall, 1'b0);

      // stray ack while idle is ignored
      @(negedge clk);
      memAck = 1'b1;
      memRdata = lineA;
      #1;
      checkOutput("stray_enable", memEnable, 1'b0);
      @(negedge clk);
      memAck = 1'b0;
      #1;
      checkOutput("stray_after_enable", memEnable, 1'b0);
      checkOutput("stray_after_stall", memStall, 1'b0);

      // same address misses again; ack arrives with the request
      detectMiss(1'b0, 32'h0000_0400, 32'h0);
      missPhase(1'b0, 32'h0000_0400, 1, lineE, 256'h0);
      finishMiss(3, 32'h5000_0000);
      hitAccess(1'b0, 32'h0000_041C, 32'h0, 32'h5000_0007);

      cpuReq = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller in the MEM stage. Services load/store requests from the pipeline and drives `mem_stall_o`, the stall that freezes the PC, IF_ID, ID_EX, EX_MEM and MEM_WB registers during a miss. Fetches and evicts 256-bit lines through a single-request/acknowledge handshake to the off-chip data memory.

## Interface
Parameters:
- `NUM_LINES`, 16: number of cache lines; must be a power of 2. The index width is log2(NUM_LINES).
- `LINE_BITS`, 256: line width in bits (8 words).

Ports:
- `clk_i`  in  1  clock
- `rst_i`  in  1  reset, asynchronous, active-high
- `cpu_req_i`  in  1  MemRead or MemWrite is active this cycle
- `cpu_we_i`  in  1  1 = store, 0 = load
- `cpu_addr_i`  in  32  byte address, word-aligned
- `cpu_data_i`  in  32  store data
- `cpu_data_o`  out  32  load data, combinational
- `mem_stall_o`  out  1  pipeline stall, combinational
- `mem_enable_o`  out  1  memory request valid
- `mem_write_o`  out  1  1 = write-back, 0 = fill
- `mem_addr_o`  out  32  line-aligned address (low 5 bits 0)
- `mem_data_o`  out  256  evicted line
- `mem_data_i`  in  256  fill line
- `mem_ack_i`  in  1  one-cycle completion pulse

## Operation
- Address split (default parameters):
  - tag = `addr[31:9]` (23 bits)
  - index = `addr[8:5]`
  - word offset = `addr[4:2]`
- Per line, the controller keeps valid, dirty, tag and data.
- Hit condition: `cpu_req_i` & valid[index] & (tag == stored tag).
- Load hit: `cpu_data_o` returns the selected word; `mem_stall_o` = 0.
- Store hit: the selected word is written at the next posedge and dirty is set.
- Miss: `mem_stall_o` = 1 in the same cycle. The CPU holds `cpu_*` inputs stable while the stall is high.
- FSM states:
  - IDLE
    - Miss with a clean or invalid victim → FILL.
    - Miss with a dirty victim → WB.
  - WB
    - `mem_enable_o`=1, `mem_write_o`=1.
    - Address = {victim tag, index, 5'b0}; `mem_data_o` = victim line.
    - On `mem_ack_i` → FILL.
  - FILL
    - `mem_enable_o`=1, `mem_write_o`=0, address = {req tag, index, 5'b0}.
    - On `mem_ack_i` → REFILL.
  - REFILL
    - Writes `mem_data_i` (captured at ack) into the line.
    - Sets valid, clears dirty, loads the tag.
    - → IDLE. The access is then re-evaluated as a hit.
- `mem_stall_o` = (state != IDLE) | (`cpu_req_i` & ~hit).
- `mem_ack_i` is ignored in IDLE and REFILL.
- `mem_enable_o` stays high continuously from FSM entry into WB or FILL until the ack cycle.
- `cpu_data_o` = 0 when `cpu_req_i`=0 or `cpu_we_i`=1.

## Timing
- Reset (asynchronous):
  - State → IDLE.
  - All valid and dirty bits → 0.
  - `mem_enable_o`=0, `mem_write_o`=0.
  - `mem_addr_o`=0, `mem_data_o`=0, `cpu_data_o`=0, `mem_stall_o`=0.
- Hit latency: 0 cycles (no stall).
- Clean miss: stall lasts (memory latency + 2) cycles: the IDLE detect cycle, FILL cycles including the ack, and REFILL. Stall deasserts in the following IDLE cycle, where the access hits.
- Dirty miss: adds the WB cycles through its ack.
- Ack in the same cycle `mem_enable_o` first rises is legal (latency 1).
- Reset mid-miss aborts the transaction. The line is not updated and `mem_enable_o` drops immediately.
- Store miss: the line is filled first, then the write happens at the hit cycle. The line ends dirty.

## Configuration
- `DCACHE_STATS_EN` defined: adds outputs `hit_cnt_o` and `miss_cnt_o` (32 bits each, reset 0, saturating at 2^32-1).
  - `hit_cnt_o` increments once per hit cycle in IDLE while not stalled.
  - `miss_cnt_o` increments once per IDLE→WB/FILL transition.
- Not defined: these ports and counters do not exist.

## Structure
- Package `dcache_pkg`:
  - State enum `{IDLE, WB, FILL, REFILL}`.
  - Tag, index and offset width constants.
  - The line type.
- Sub-module `dcache_sram` holds tag/valid/dirty/data arrays:
  - Asynchronous read.
  - Synchronous write with full-line and single-word write modes.
  - Asynchronous clear of valid and dirty on `rst_i`.
- `dcache_controller` contains the FSM, hit logic and memory interface.

## Test plan
- Cold load `0x0000_0104`:
  - Stall rises at once.
  - FILL request with `mem_addr_o`=0x100, `mem_write_o`=0.
  - Ack after 10 cycles with word1=0xDEAD_BEEF.
  - Stall drops one cycle after REFILL; `cpu_data_o`=0xDEAD_BEEF.
- Repeated load `0x104`, then store `0x108`←0x1234_5678: both hit, no stall, `mem_enable_o` stays 0, line becomes dirty.
- Load `0x0000_0308` (same index, different tag) after the previous test:
  - WB to 0x100 with `mem_data_o` word2=0x1234_5678.
  - Then FILL from 0x300.
  - Stall covers both acks plus 2 cycles.
- Store miss to `0x200`←0xA5A5_A5A5:
  - Fill from 0x200.
  - A following load of `0x200` hits and returns 0xA5A5_A5A5.
  - A later eviction writes it back.
- Reset asserted during FILL: `mem_enable_o` and stall drop at once, and the next access to the same address misses.
- Ack issued while IDLE, and an ack in the same cycle as the request: the first is ignored; the second completes with stall length 3.
